// File: rtl/mem_port_arbiter_if.sv
// Requester (IF / DM) and memory-side signals of the unified-memory arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: DM has priority, IF is forced through after STARVE_MAX DM wins.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          conflict_cnt,
    output logic [7:0]           starve_hits
`endif
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [LAT_W-1:0]   r_lat;
    logic [SW-1:0]      r_starve;
    logic               r_owner_dm;
    logic               r_we_op;
    logic               r_err;
    logic               r_if_gnt;
    logic               r_if_valid;
    logic [DATA_W-1:0]  r_if_rdata;
    logic               r_dm_gnt;
    logic               r_dm_valid;
    logic [DATA_W-1:0]  r_dm_rdata;
    logic               r_dm_err;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_busy;

    logic w_force_if;
    logic w_dm_win;
    logic w_if_win;
    logic w_dm_oob;

    assign w_force_if = bus.if_req && (r_starve == SW'(STARVE_MAX));
    assign w_dm_win   = bus.dm_req && !w_force_if;
    assign w_if_win   = bus.if_req && !w_dm_win;
    assign w_dm_oob   = |bus.dm_addr[31:ADDR_W];

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_err    = r_dm_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

`ifdef ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [7:0]  r_starve_hits;

    assign conflict_cnt = r_conflict_cnt;
    assign starve_hits  = r_starve_hits;

    // Conflict and forced-IF statistics, sampled on IDLE edges only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= 16'd0;
            r_starve_hits  <= 8'd0;
        end else if (r_state == S_IDLE) begin
            if (bus.if_req && bus.dm_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            if (w_force_if && bus.dm_req && (r_starve_hits != 8'hFF)) begin
                r_starve_hits <= r_starve_hits + 8'd1;
            end
        end
    end
`endif

    // Arbitration FSM with registered grant, memory and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat       <= LAT_W'(0);
            r_starve    <= SW'(0);
            r_owner_dm  <= 1'b0;
            r_we_op     <= 1'b0;
            r_err       <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= {DATA_W{1'b0}};
            r_dm_gnt    <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_dm_rdata  <= {DATA_W{1'b0}};
            r_dm_err    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_if_gnt <= 1'b0;
            r_dm_gnt <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_dm_win) begin
                        r_dm_gnt    <= 1'b1;
                        r_owner_dm  <= 1'b1;
                        r_we_op     <= bus.dm_we;
                        r_err       <= w_dm_oob;
                        r_mem_en    <= !w_dm_oob;
                        r_mem_we    <= bus.dm_we && !w_dm_oob;
                        r_mem_addr  <= bus.dm_addr[ADDR_W-1:0];
                        r_mem_wdata <= bus.dm_wdata;
                        r_lat       <= LAT_W'(MEM_LAT);
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end else if (w_if_win) begin
                        r_if_gnt    <= 1'b1;
                        r_owner_dm  <= 1'b0;
                        r_we_op     <= 1'b0;
                        r_err       <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= bus.if_addr;
                        r_lat       <= LAT_W'(MEM_LAT);
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                    if (!bus.if_req || !w_dm_win) begin
                        r_starve <= SW'(0);
                    end else if (r_starve != SW'(STARVE_MAX)) begin
                        r_starve <= r_starve + SW'(1);
                    end else begin
                        r_starve <= r_starve;
                    end
                end
                S_WAIT: begin
                    // mem_en is itself registered, so read data is due one edge after the count expires
                    if (r_lat == LAT_W'(0)) begin
                        r_state <= S_RESP;
                        if (r_owner_dm) begin
                            r_dm_valid <= 1'b1;
                            r_dm_err   <= r_err;
                            if (r_err) begin
                                r_dm_rdata <= {DATA_W{1'b0}};
                            end else if (!r_we_op) begin
                                r_dm_rdata <= bus.mem_rdata;
                            end else begin
                                r_dm_rdata <= r_dm_rdata;
                            end
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                S_RESP: begin
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_dm_err   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_dm_err   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule
